// File: rtl/blk_mem_gen_pkg.sv
// Shared constants and word layouts for the hit-map block memories.
// The hit-new map (HNM) uses blk_mem_gen with DATA_WIDTH = NCOLS_HNM and
// ADDR_WIDTH = ROWINDEXBITS_HNM. The hit-count map (HCM) uses
// DATA_WIDTH = NCOLS_HCM and ADDR_WIDTH = ROWINDEXBITS_HCM.
// Optional feature macro: BLK_MEM_GEN_OUTREG_EN (extra output register per port).
package blk_mem_pkg;

  // Hit-new map geometry: one bit per column, one word per row.
  localparam int NCOLS_HNM        = 32;
  localparam int ROWINDEXBITS_HNM = 8;

  // Hit-list map row index and hit counter widths.
  localparam int ROWINDEXBITS_HLM = 8;
  localparam int MAXHITNBITS      = 8;

  // Hit-count map: each word is {HLM address, hit count}.
  localparam int NCOLS_HCM        = ROWINDEXBITS_HLM + MAXHITNBITS;
  localparam int ROWINDEXBITS_HCM = 8;

  // Cycles from address at an edge to valid dout.
`ifdef BLK_MEM_GEN_OUTREG_EN
  localparam int READ_LATENCY = 2;
`else
  localparam int READ_LATENCY = 1;
`endif

  // HCM word: upper bits address the hit-list map, lower bits count hits.
  typedef struct packed {
    logic [ROWINDEXBITS_HLM-1:0] hlm_addr;
    logic [MAXHITNBITS-1:0]      hit_count;
  } hcm_word_t;

  // Build an HCM word from its two fields.
  function automatic hcm_word_t hcm_pack(input logic [ROWINDEXBITS_HLM-1:0] hlm_addr,
                                         input logic [MAXHITNBITS-1:0]      hit_count);
    hcm_word_t w;
    w.hlm_addr  = hlm_addr;
    w.hit_count = hit_count;
    return w;
  endfunction

endpackage

// File: rtl/blk_mem_port.sv
// One port of the true dual-port RAM: enable/write qualification and the
// read-first output register, plus an optional second output stage when
// BLK_MEM_GEN_OUTREG_EN is defined. The storage array lives in the parent.
module blk_mem_port
  import blk_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  // Writes are dropped while reset is held so the array sees no traffic.
  assign wr_en_o = en_i & we_i & rst_ni;

  // Capture the addressed word when enabled, otherwise hold.
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps latches from being inferred.
    rdata_d = rdata_q;
    if (en_i) rdata_d = mem_rdata_i;
  end

  // First output stage; mem_rdata_i is the pre-write word, giving read-first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

`ifdef BLK_MEM_GEN_OUTREG_EN
  logic                  en_q;
  logic [DATA_WIDTH-1:0] pipe_d, pipe_q;

  // Second stage only follows the first when the port was enabled last cycle.
  always_comb begin
    pipe_d = pipe_q;
    if (en_q) pipe_d = rdata_q;
  end

  // Output pipeline register and the delayed enable that qualifies it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q   <= 1'b0;
      pipe_q <= '0;
    end else begin
      en_q   <= en_i;
      pipe_q <= pipe_d;
    end
  end

  assign dout_o = pipe_q;
`else
  assign dout_o = rdata_q;
`endif

endmodule

// File: rtl/blk_mem_gen.sv
// True dual-port block RAM, single clock, read-first on both ports.
// Port A wins when both ports write the same word in one cycle.
// Define BLK_MEM_GEN_OUTREG_EN for a 2-cycle read latency (output register).
module blk_mem_gen
  import blk_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  ena,
  input  logic                  enb,
  input  logic                  wea,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] douta,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // NOTE: the array has no reset so it maps onto block RAM; the declaration
  // value gives the all-zero power-up contents and reset leaves words intact.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic wr_a, wr_b;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

  // Asynchronous array reads feed the port registers with the pre-edge word.
  assign rdata_a = mem_q[addra];
  assign rdata_b = mem_q[addrb];

  blk_mem_port #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port_a (
    .clk_i       (clock),
    .rst_ni      (resetN),
    .en_i        (ena),
    .we_i        (wea),
    .mem_rdata_i (rdata_a),
    .wr_en_o     (wr_a),
    .dout_o      (douta)
  );

  blk_mem_port #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port_b (
    .clk_i       (clock),
    .rst_ni      (resetN),
    .en_i        (enb),
    .we_i        (web),
    .mem_rdata_i (rdata_b),
    .wr_en_o     (wr_b),
    .dout_o      (doutb)
  );

  // Shared array write; port A is applied last so it wins a same-address collision.
  always_ff @(posedge clock) begin
    if (wr_b) mem_q[addrb] <= dinb;
    if (wr_a) mem_q[addra] <= dina;
  end

endmodule

// File: tb/tb_blk_mem_gen.sv
// Self-checking bench for blk_mem_gen (default 32-bit x 256 words).
// Directed vector table, hand sequences for reset and clear sweep, then
// random traffic against an array-based reference model.
module tb_blk_mem_gen;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 2 ** AW;
`ifdef BLK_MEM_GEN_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clock = 1'b0;
  logic          resetN;
  logic          ena, enb, wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb;
  logic [DW-1:0] douta, doutb;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] s1_a, s1_b, s2_a, s2_b;
  logic          prev_en_a, prev_en_b;

  always #5 clock = ~clock;

  blk_mem_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock  (clock),
    .resetN (resetN),
    .ena    (ena),
    .enb    (enb),
    .wea    (wea),
    .web    (web),
    .addra  (addra),
    .addrb  (addrb),
    .dina   (dina),
    .dinb   (dinb),
    .douta  (douta),
    .doutb  (doutb)
  );

  typedef struct {
    string         name;
    logic          ea, wa;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          eb, wb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic [DW-1:0] exp_a, exp_b;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_a();
    return (LAT == 2) ? s2_a : s1_a;
  endfunction

  function automatic logic [DW-1:0] model_b();
    return (LAT == 2) ? s2_b : s1_b;
  endfunction

  task automatic model_reset();
    s1_a = '0; s1_b = '0; s2_a = '0; s2_b = '0;
    prev_en_a = 1'b0; prev_en_b = 1'b0;
  endtask

  // One clock: drive inputs, advance past the edge, update the model, settle.
  task automatic cycle(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic [DW-1:0] old_a, old_b;
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    @(posedge clock);
    if (resetN) begin
      old_a = mem_m[aa];
      old_b = mem_m[ab];
      if (prev_en_a) s2_a = s1_a;
      if (prev_en_b) s2_b = s1_b;
      if (ea) s1_a = old_a;
      if (eb) s1_b = old_b;
      prev_en_a = ea;
      prev_en_b = eb;
      if (eb && wb) mem_m[ab] = db;
      if (ea && wa) mem_m[aa] = da;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  vec_t vecs [10];

  initial begin
    resetN = 1'b0;
    ena = 0; enb = 0; wea = 0; web = 0;
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    model_reset();

    vecs[0] = '{"wr5_rdfirst", 1,1,8'd5,32'hDEADBEEF, 1,0,8'd5,32'h0,        32'h0,        32'h0};
    vecs[1] = '{"rd5_basic",   1,0,8'd5,32'h0,        1,0,8'd5,32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{"wr3_init",    1,1,8'd3,32'h1,        1,0,8'd9,32'h0,        32'h0,        32'h0};
    vecs[3] = '{"wr3_rdfirst", 1,1,8'd3,32'h2,        1,0,8'd3,32'h0,        32'h1,        32'h1};
    vecs[4] = '{"rd3_new",     1,0,8'd3,32'h0,        1,0,8'd3,32'h0,        32'h2,        32'h2};
    vecs[5] = '{"collide7",    1,1,8'd7,32'hA,        1,1,8'd7,32'hB,        32'h0,        32'h0};
    vecs[6] = '{"rd7_awins",   1,0,8'd7,32'h0,        1,0,8'd7,32'h0,        32'hA,        32'hA};
    vecs[7] = '{"rd5_prime",   1,0,8'd5,32'h0,        1,0,8'd9,32'h0,        32'hDEADBEEF, 32'h0};
    vecs[8] = '{"ena0_hold",   0,1,8'd9,32'hFF,       1,0,8'd3,32'h0,        32'hDEADBEEF, 32'h2};
    vecs[9] = '{"rd9_unwrit",  1,0,8'd9,32'h0,        1,0,8'd9,32'h0,        32'h0,        32'h0};

    // Reset state
    #2;
    check("reset_douta", douta, '0);
    check("reset_doutb", doutb, '0);
    @(negedge clock);
    resetN = 1'b1;
    #1;

    // Directed vectors: each op, then enough idle cycles to reach dout.
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].ea, vecs[i].wa, vecs[i].aa, vecs[i].da,
            vecs[i].eb, vecs[i].wb, vecs[i].ab, vecs[i].db);
      idle(LAT - 1);
      check({vecs[i].name, "_a"}, douta, vecs[i].exp_a);
      check({vecs[i].name, "_b"}, doutb, vecs[i].exp_b);
    end

    // Asynchronous reset clears outputs but not the array; writes ignored during reset.
    cycle(1, 1, 8'd1, 32'h55, 0, 0, '0, '0);
    cycle(1, 0, 8'd1, 32'h0, 1, 0, 8'd1, 32'h0);
    idle(LAT - 1);
    check("pre_reset_a", douta, 32'h55);
    check("pre_reset_b", doutb, 32'h55);
    #2;
    resetN = 1'b0;
    model_reset();
    #1;
    check("async_rst_a", douta, '0);
    check("async_rst_b", doutb, '0);
    cycle(1, 1, 8'd1, 32'h77, 1, 1, 8'd2, 32'h77);
    check("in_rst_a", douta, '0);
    check("in_rst_b", doutb, '0);
    #2;
    resetN = 1'b1;
    cycle(1, 0, 8'd1, 32'h0, 1, 0, 8'd2, 32'h0);
    idle(LAT - 1);
    check("post_rst_rd1", douta, 32'h55);
    check("post_rst_rd2", doutb, 32'h0);

    // Random traffic, concentrated on few addresses to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
      check("rand_a", douta, model_a());
      check("rand_b", doutb, model_b());
    end

    // Clear sweep: two rows per cycle, then read every row back.
    for (int r = 0; r < DEPTH; r += 2)
      cycle(1, 1, AW'(r), '0, 1, 1, AW'(r + 1), '0);
    for (int r = 0; r < DEPTH; r += 2) begin
      cycle(1, 0, AW'(r), '0, 1, 0, AW'(r + 1), '0);
      idle(LAT - 1);
      check("sweep_a", douta, '0);
      check("sweep_b", doutb, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blk_mem_gen.md
BLK_MEM_GEN -- requirements
Module: blk_mem_gen

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (= NCOLS_HNM for hit-new map, = NCOLS_HCM for hit-count map).
- REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width; depth = 2**ADDR_WIDTH words.
- REQ-003 SHALL have port clock, input, 1, single clock shared by both ports; rising-edge.
- REQ-004 SHALL have port resetN, input, 1, asynchronous active-low reset.
- REQ-005 SHALL have ports ena and enb, each input, 1, port A / port B enable.
- REQ-006 SHALL have ports wea and web, each input, 1, port A / port B write enable.
- REQ-007 SHALL have ports addra and addrb, each input, ADDR_WIDTH, port A / port B word address.
- REQ-008 SHALL have ports dina and dinb, each input, DATA_WIDTH, port A / port B write data.
- REQ-009 SHALL have ports douta and doutb, each output, DATA_WIDTH, port A / port B registered read data.

Function
- REQ-010 SHALL implement a true dual-port RAM: each port independently reads or writes any address every cycle.
- REQ-011 Port X with enX=1 and weX=1 at a clock edge SHALL store dinX at addrX.
- REQ-012 Port X with enX=1 SHALL load doutX with the word at addrX on that edge: read latency 1 cycle (addr presented at edge N -> data valid after edge N).
- REQ-013 Write mode SHALL be read-first: a write on port X returns the pre-write word on doutX.
- REQ-014 Port X reading the address port Y writes in the same cycle SHALL return the old word; the new word SHALL be visible from the next read.
- REQ-015 Both ports writing the same address in the same cycle: port A data SHALL win; both douts return the old word.
- REQ-016 enX=0 SHALL suppress the read and write on port X; doutX SHALL hold its value.
- REQ-017 Out-of-range addresses cannot occur (depth = 2**ADDR_WIDTH); address arithmetic SHALL not wrap or alias.
- REQ-018 Memory contents SHALL be all-zero after configuration/power-up; no other initialisation file.

Reset
- REQ-019 resetN=0 SHALL asynchronously force douta and doutb (and any pipeline registers) to 0.
- REQ-020 Reset SHALL NOT clear the memory array; stored words survive reset.
- REQ-021 Writes and reads SHALL be ignored while resetN=0; operation resumes on the first edge after deassertion.
- REQ-022 Reset asserted mid-write SHALL leave the target word either fully old or fully new, never partial.

Configuration
- REQ-023 Macro BLK_MEM_GEN_OUTREG_EN SHALL, when defined, add one output pipeline register per port: read latency 2 cycles; the register updates only when enX=1 one cycle earlier; it resets to 0.
- REQ-024 Without BLK_MEM_GEN_OUTREG_EN, read latency SHALL be exactly 1 cycle, per REQ-012.

Structure
- REQ-025 Package blk_mem_pkg SHALL hold the shared constants NCOLS_HNM, ROWINDEXBITS_HNM, NCOLS_HCM, ROWINDEXBITS_HCM, ROWINDEXBITS_HLM and MAXHITNBITS.
- REQ-026 The package SHALL define the HCM word layout: upper ROWINDEXBITS_HLM bits are the HLM address; lower bits are the hit count.
- REQ-027 The hit-new memory SHALL be instantiated with DATA_WIDTH=NCOLS_HNM and ADDR_WIDTH=ROWINDEXBITS_HNM.
- REQ-028 The hit-count memory SHALL be instantiated with DATA_WIDTH=NCOLS_HCM and ADDR_WIDTH=ROWINDEXBITS_HCM.
- REQ-029 Sub-module blk_mem_port SHALL implement one port's enable, write, read-first output and optional pipeline; it is instantiated twice around one shared array.

Verification
- REQ-030 Write/read basic: port A write 0xDEADBEEF to addr 5, then port B read addr 5 -> doutb=0xDEADBEEF one cycle after the address (two with OUTREG).
- REQ-031 Read-first: addr 3 holds 0x1, port A writes 0x2 to addr 3 -> douta=0x1 that cycle; a next-cycle read gives 0x2.
- REQ-032 Collision: port A writes 0xA and port B writes 0xB to addr 7 in the same cycle -> a later read of addr 7 returns 0xA.
- REQ-033 Enable gating: ena=0 with wea=1 writing 0xFF to addr 9 -> addr 9 stays 0 and douta holds its prior value.
- REQ-034 Reset: write 0x55 to addr 1, pulse resetN low asynchronously -> douta=doutb=0 immediately; a read of addr 1 after reset returns 0x55.
- REQ-035 Clear sweep: both ports write 0 to all 2**ADDR_WIDTH rows, two rows per cycle -> every subsequent read returns 0.
